// File: rtl/ysyx_22050019_icache_pkg.sv
// rtl/ysyx_22050019_icache_pkg.sv - shared state encoding, response codes and address helpers for the n-way icache
package ysyx_22050019_icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_AR,
    S_R,
    S_RESP,
    S_FENCE
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Extract width bits starting at lsb; callers size the result to the field.
  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int unsigned lsb,
                                             input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (addr >> lsb) & mask;
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int unsigned word_off,
                                             input int unsigned beat_w, input int unsigned index_w);
    return addr_field(addr, word_off + beat_w, index_w);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int unsigned word_off,
                                           input int unsigned beat_w, input int unsigned index_w,
                                           input int unsigned tag_w);
    return addr_field(addr, word_off + beat_w + index_w, tag_w);
  endfunction

endpackage

// File: rtl/ysyx_22050019_icache_repl.sv
// rtl/ysyx_22050019_icache_repl.sv - per-set round-robin pointers with invalid-first victim selection
module ysyx_22050019_icache_repl #(
  parameter int WAYS = 4,
  parameter int SETS = 16,
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int IW = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IW-1:0]   set,
  input  logic [WAYS-1:0] valid,
  input  logic            upd,
  output logic [WW-1:0]   victim
);

  logic [WW-1:0] rr_ptr [SETS];

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    victim = rr_ptr[set];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WW'(w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else if (upd) begin
      rr_ptr[set] <= (rr_ptr[set] == WW'(WAYS - 1)) ? '0 : rr_ptr[set] + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_22050019_icache_nway.sv
// rtl/ysyx_22050019_icache_nway.sv - n-way set-associative icache with burst refill and fence.i invalidate
// Optional perf counters: define YSYX_22050019_ICACHE_PERF_EN.
module ysyx_22050019_icache_nway
  import ysyx_22050019_icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int WAYS       = 4,
  parameter int SETS       = 16,
  parameter int LINE_BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  output logic                  r_data_valid_o,
  input  logic                  r_data_ready_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  cache_ar_valid_o,
  input  logic                  cache_ar_ready_i,
  output logic [ADDR_WIDTH-1:0] cache_ar_addr_o,
  output logic [7:0]            cache_ar_len_o,
  input  logic                  cache_r_valid_i,
  output logic                  cache_r_ready_o,
  input  logic [DATA_WIDTH-1:0] cache_r_data_i,
  input  logic [1:0]            cache_r_resp_i,
  input  logic                  cache_r_last_i,
  input  logic                  fence_i_valid_i,
  output logic                  fence_i_ready_o
`ifdef YSYX_22050019_ICACHE_PERF_EN
  ,
  output logic [31:0]           perf_hit_o,
  output logic [31:0]           perf_miss_o
`endif
);

  localparam int WORD_OFF = $clog2(DATA_WIDTH / 8);
  localparam int BEAT_W   = $clog2(LINE_BEATS);
  localparam int INDEX_W  = $clog2(SETS);
  localparam int TAG_W    = ADDR_WIDTH - INDEX_W - BEAT_W - WORD_OFF;
  localparam int WW       = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int IW       = (SETS > 1) ? INDEX_W : 1;
  localparam int BW       = (LINE_BEATS > 1) ? BEAT_W : 1;

  state_e                  state;
  logic                    idle_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [BW-1:0]           beat_cnt;
  logic                    err_q;
  logic [WW-1:0]           way_q;
  logic                    repl_q;

  logic [TAG_W-1:0]        tag_q   [WAYS][SETS];
  logic [WAYS-1:0]         valid_q [SETS];
  logic [DATA_WIDTH-1:0]   data_q  [WAYS][SETS][LINE_BEATS];

  logic [IW-1:0]           set_idx;
  logic [BW-1:0]           req_beat;
  logic [TAG_W-1:0]        tag_in;
  logic                    hit;
  logic [WW-1:0]           hit_way;
  logic [WW-1:0]           victim;
  logic                    last_beat;
  logic                    err_next;
  logic                    repl_upd;

  assign set_idx  = IW'(addr_index(64'(addr_q), WORD_OFF, BEAT_W, INDEX_W));
  assign req_beat = BW'(addr_field(64'(addr_q), WORD_OFF, BEAT_W));
  assign tag_in   = TAG_W'(addr_tag(64'(addr_q), WORD_OFF, BEAT_W, INDEX_W, TAG_W));

  assign ar_ready_o      = idle_q & ~fence_i_valid_i;
  assign cache_ar_addr_o = (addr_q >> (BEAT_W + WORD_OFF)) << (BEAT_W + WORD_OFF);
  assign cache_ar_len_o  = 8'(LINE_BEATS - 1);

  // A burst whose last flag disagrees with the beat count is treated like a bad response.
  assign last_beat = (beat_cnt == BW'(LINE_BEATS - 1));
  assign err_next  = err_q | (cache_r_resp_i != RESP_OKAY) | (cache_r_last_i != last_beat);
  assign repl_upd  = (state == S_R) && cache_r_valid_i && last_beat && repl_q;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_q[w][set_idx] == tag_in)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  ysyx_22050019_icache_repl #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_repl (
    .clk    (clk),
    .rst_n  (rst_n),
    .set    (set_idx),
    .valid  (valid_q[set_idx]),
    .upd    (repl_upd),
    .victim (victim)
  );

  always_ff @(posedge clk) begin
    if (state == S_LOOKUP && !hit) tag_q[victim][set_idx] <= tag_in;
    if (state == S_R && cache_r_valid_i) data_q[way_q][set_idx][beat_cnt] <= cache_r_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      idle_q           <= 1'b1;
      addr_q           <= '0;
      beat_cnt         <= '0;
      err_q            <= 1'b0;
      way_q            <= '0;
      repl_q           <= 1'b0;
      r_data_o         <= '0;
      r_resp_o         <= RESP_OKAY;
      r_data_valid_o   <= 1'b0;
      cache_ar_valid_o <= 1'b0;
      cache_r_ready_o  <= 1'b0;
      fence_i_ready_o  <= 1'b0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fence_i_valid_i) begin
            state           <= S_FENCE;
            idle_q          <= 1'b0;
            fence_i_ready_o <= 1'b1;
          end else if (ar_valid_i) begin
            addr_q <= ar_addr_i;
            state  <= S_LOOKUP;
            idle_q <= 1'b0;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            r_data_o       <= data_q[hit_way][set_idx][req_beat];
            r_resp_o       <= RESP_OKAY;
            r_data_valid_o <= 1'b1;
            state          <= S_RESP;
          end else begin
            valid_q[set_idx][victim] <= 1'b0;
            way_q            <= victim;
            repl_q           <= &valid_q[set_idx];
            beat_cnt         <= '0;
            err_q            <= 1'b0;
            cache_ar_valid_o <= 1'b1;
            state            <= S_AR;
          end
        end
        S_AR: begin
          if (cache_ar_ready_i) begin
            cache_ar_valid_o <= 1'b0;
            cache_r_ready_o  <= 1'b1;
            state            <= S_R;
          end
        end
        S_R: begin
          if (cache_r_valid_i) begin
            if (beat_cnt == req_beat) r_data_o <= cache_r_data_i;
            err_q <= err_next;
            if (last_beat) begin
              if (!err_next) valid_q[set_idx][way_q] <= 1'b1;
              r_resp_o        <= err_next ? RESP_SLVERR : RESP_OKAY;
              r_data_valid_o  <= 1'b1;
              cache_r_ready_o <= 1'b0;
              beat_cnt        <= '0;
              state           <= S_RESP;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_RESP: begin
          if (r_data_ready_i) begin
            r_data_valid_o <= 1'b0;
            idle_q         <= 1'b1;
            state          <= S_IDLE;
          end
        end
        S_FENCE: begin
          for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
          fence_i_ready_o <= 1'b0;
          idle_q          <= 1'b1;
          state           <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          idle_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef YSYX_22050019_ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hit_o  <= '0;
      perf_miss_o <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit && perf_hit_o != '1) perf_hit_o <= perf_hit_o + 32'd1;
      if (!hit && perf_miss_o != '1) perf_miss_o <= perf_miss_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050019_icache_nway.sv
// tb/tb_ysyx_22050019_icache_nway.sv - directed self-checking bench for the n-way icache
module tb_ysyx_22050019_icache_nway;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ar_valid_i;
  logic        ar_ready_o;
  logic [31:0] ar_addr_i;
  logic        r_data_valid_o;
  logic        r_data_ready_i;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        cache_ar_valid_o;
  logic        cache_ar_ready_i;
  logic [31:0] cache_ar_addr_o;
  logic [7:0]  cache_ar_len_o;
  logic        cache_r_valid_i;
  logic        cache_r_ready_o;
  logic [63:0] cache_r_data_i;
  logic [1:0]  cache_r_resp_i;
  logic        cache_r_last_i;
  logic        fence_i_valid_i;
  logic        fence_i_ready_o;
`ifdef YSYX_22050019_ICACHE_PERF_EN
  logic [31:0] perf_hit_o;
  logic [31:0] perf_miss_o;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ysyx_22050019_icache_nway dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ar_valid_i       (ar_valid_i),
    .ar_ready_o       (ar_ready_o),
    .ar_addr_i        (ar_addr_i),
    .r_data_valid_o   (r_data_valid_o),
    .r_data_ready_i   (r_data_ready_i),
    .r_data_o         (r_data_o),
    .r_resp_o         (r_resp_o),
    .cache_ar_valid_o (cache_ar_valid_o),
    .cache_ar_ready_i (cache_ar_ready_i),
    .cache_ar_addr_o  (cache_ar_addr_o),
    .cache_ar_len_o   (cache_ar_len_o),
    .cache_r_valid_i  (cache_r_valid_i),
    .cache_r_ready_o  (cache_r_ready_o),
    .cache_r_data_i   (cache_r_data_i),
    .cache_r_resp_i   (cache_r_resp_i),
    .cache_r_last_i   (cache_r_last_i),
    .fence_i_valid_i  (fence_i_valid_i),
    .fence_i_ready_o  (fence_i_ready_o)
`ifdef YSYX_22050019_ICACHE_PERF_EN
    ,
    .perf_hit_o       (perf_hit_o),
    .perf_miss_o      (perf_miss_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {~a, a};
  endfunction

  // Drives one fetch and plays the memory side for any refill bursts it triggers.
  task automatic fetch(input logic [31:0] addr, input int err_beat, input int last_at, input int hold,
                       output logic [63:0] data, output logic [1:0] resp, output int nburst,
                       output int lat, output int ar_lat, output logic [31:0] ar_addr);
    int hs;
    int guard;
    logic [31:0] line;
    nburst = 0; lat = -1; ar_lat = -1; ar_addr = '0; data = '0; resp = '0;
    ar_valid_i = 1'b1;
    ar_addr_i  = addr;
    #1;
    guard = 0;
    while (!ar_ready_o && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!ar_ready_o) begin
      chk("ar_ready_timeout", 64'(ar_ready_o), 64'd1);
      ar_valid_i = 1'b0;
      return;
    end
    hs = cyc + 1;
    @(negedge clk);
    ar_valid_i = 1'b0;
    guard = 0;
    while (!r_data_valid_o && guard < 300) begin
      if (cache_ar_valid_o) begin
        if (ar_lat < 0) ar_lat = cyc - hs + 1;
        nburst++;
        ar_addr = cache_ar_addr_o;
        chk("ar_len", 64'(cache_ar_len_o), 64'd3);
        cache_ar_ready_i = 1'b1;
        @(negedge clk);
        cache_ar_ready_i = 1'b0;
        line = ar_addr;
        for (int b = 0; b < 4; b++) begin
          chk("r_ready", 64'(cache_r_ready_o), 64'd1);
          cache_r_valid_i = 1'b1;
          cache_r_data_i  = mem_word(line + 32'(b * 8));
          cache_r_resp_i  = (b == err_beat) ? 2'b10 : 2'b00;
          cache_r_last_i  = (last_at >= 0) ? (b == last_at) : (b == 3);
          @(negedge clk);
        end
        cache_r_valid_i = 1'b0;
        cache_r_last_i  = 1'b0;
        chk("resp_after_last", 64'(r_data_valid_o), 64'd1);
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    if (!r_data_valid_o) begin
      chk("resp_timeout", 64'(r_data_valid_o), 64'd1);
      return;
    end
    lat  = cyc - hs + 1;
    data = r_data_o;
    resp = r_resp_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(r_data_valid_o), 64'd1);
      chk("hold_data", r_data_o, mem_word({addr[31:3], 3'b000}));
      chk("hold_resp", 64'(r_resp_o), 64'd0);
      chk("hold_ar_ready", 64'(ar_ready_o), 64'd0);
    end
    r_data_ready_i = 1'b1;
    @(negedge clk);
    r_data_ready_i = 1'b0;
    chk("ar_ready_back", 64'(ar_ready_o), 64'd1);
  endtask

  initial begin
    logic [63:0] d;
    logic [1:0]  rs;
    int          nb, lt, al, pulses;
    logic [31:0] aa;
    logic [31:0] fill_addr [5];

    rst_n = 1'b0; ar_valid_i = 1'b0; ar_addr_i = '0; r_data_ready_i = 1'b0;
    cache_ar_ready_i = 1'b0; cache_r_valid_i = 1'b0; cache_r_data_i = '0;
    cache_r_resp_i = '0; cache_r_last_i = 1'b0; fence_i_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ar_ready", 64'(ar_ready_o), 64'd1);
    chk("rst_r_valid", 64'(r_data_valid_o), 64'd0);
    chk("rst_r_data", r_data_o, 64'd0);
    chk("rst_r_resp", 64'(r_resp_o), 64'd0);
    chk("rst_c_ar_valid", 64'(cache_ar_valid_o), 64'd0);
    chk("rst_c_r_ready", 64'(cache_r_ready_o), 64'd0);
    chk("rst_fence_ready", 64'(fence_i_ready_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss, then a hit on the neighbouring beat of the same line.
    fetch(32'h8000_0010, -1, -1, 0, d, rs, nb, lt, al, aa);
    chk("cold_bursts", 64'(nb), 64'd1);
    chk("cold_ar_addr", 64'(aa), 64'h8000_0000);
    chk("cold_ar_lat", 64'(al), 64'd2);
    chk("cold_data", d, 64'h7FFF_FFEF_8000_0010);
    chk("cold_resp", 64'(rs), 64'd0);
    fetch(32'h8000_0018, -1, -1, 0, d, rs, nb, lt, al, aa);
    chk("hit_bursts", 64'(nb), 64'd0);
    chk("hit_lat", 64'(lt), 64'd2);
    chk("hit_data", d, 64'h7FFF_FFE7_8000_0018);

    // Five lines in set 0: the fifth evicts way 0, the refetch evicts way 1.
    fill_addr = '{32'h8000_0200, 32'h8000_0400, 32'h8000_0600, 32'h8000_0800, 32'h8000_0000};
    foreach (fill_addr[i]) begin
      fetch(fill_addr[i], -1, -1, 0, d, rs, nb, lt, al, aa);
      chk("fill_bursts", 64'(nb), 64'd1);
      chk("fill_ar_addr", 64'(aa), 64'(fill_addr[i]));
      chk("fill_data", d, mem_word(fill_addr[i]));
    end
    fetch(32'h8000_0400, -1, -1, 0, d, rs, nb, lt, al, aa);
    chk("rr_keep_way2", 64'(nb), 64'd0);
    fetch(32'h8000_0208, -1, -1, 0, d, rs, nb, lt, al, aa);
    chk("rr_evict_way1", 64'(nb), 64'd1);
    chk("rr_evict_data", d, 64'h7FFF_FDF7_8000_0208);

    // SLVERR on beat 1 leaves the line invalid.
    fetch(32'h8000_0028, 1, -1, 0, d, rs, nb, lt, al, aa);
    chk("slverr_resp", 64'(rs), 64'd2);
    chk("slverr_ar_addr", 64'(aa), 64'h8000_0020);
    fetch(32'h8000_0028, -1, -1, 0, d, rs, nb, lt, al, aa);
    chk("slverr_reburst", 64'(nb), 64'd1);
    chk("slverr_retry_resp", 64'(rs), 64'd0);
    chk("slverr_retry_data", d, 64'h7FFF_FFD7_8000_0028);

    // Early last flag on the second beat.
    fetch(32'h8000_0040, -1, 1, 0, d, rs, nb, lt, al, aa);
    chk("early_last_resp", 64'(rs), 64'd2);
    fetch(32'h8000_0040, -1, -1, 0, d, rs, nb, lt, al, aa);
    chk("early_last_reburst", 64'(nb), 64'd1);
    chk("early_last_retry_resp", 64'(rs), 64'd0);

    // Fence and fetch together: fence wins, then the cached line misses.
    fence_i_valid_i = 1'b1;
    ar_valid_i      = 1'b1;
    ar_addr_i       = 32'h8000_0400;
    #1;
    chk("fence_blocks_ar", 64'(ar_ready_o), 64'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (fence_i_ready_o) begin
        pulses++;
        fence_i_valid_i = 1'b0;
        ar_valid_i      = 1'b0;
      end
    end
    chk("fence_pulses", 64'(pulses), 64'd1);
    fetch(32'h8000_0400, -1, -1, 0, d, rs, nb, lt, al, aa);
    chk("post_fence_miss", 64'(nb), 64'd1);
    chk("post_fence_data", d, 64'h7FFF_FBFF_8000_0400);

    // Response held five cycles by the consumer.
    fetch(32'h8000_0400, -1, -1, 5, d, rs, nb, lt, al, aa);
    chk("hold_hit", 64'(nb), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/ysyx_22050019_icache_nway.md
# ysyx_22050019_icache_nway

Parametrised N-way set-associative instruction cache with multi-beat burst line refill, per-set round-robin replacement and a `fence.i` invalidate port. It is the read-only successor of the 2-way, 64-bit-line icache. It sits between the IFU fetch request channel (upstream) and the AXI-style read master toward the memory arbiter (downstream).

## Interface
Parameters:
- `ADDR_WIDTH`, 32, physical address width
- `DATA_WIDTH`, 64, fetch/bus word width in bits (power of 2, ≥32)
- `WAYS`, 4, associativity (power of 2, 1..8)
- `SETS`, 16, sets per way (power of 2)
- `LINE_BEATS`, 4, bus beats per line (power of 2, 1..16)
- Derived: `WORD_OFF=log2(DATA_WIDTH/8)`, `BEAT_W=log2(LINE_BEATS)`, `INDEX_W=log2(SETS)`, `TAG_W=ADDR_WIDTH-INDEX_W-BEAT_W-WORD_OFF`

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `ar_valid_i` / `ar_ready_o`  in/out  1  fetch request handshake
- `ar_addr_i`  in  ADDR_WIDTH  fetch address; low `WORD_OFF` bits ignored
- `r_data_valid_o` / `r_data_ready_i`  out/in  1  fetch response handshake
- `r_data_o`  out  DATA_WIDTH  fetched word
- `r_resp_o`  out  2  00 OKAY, 10 SLVERR
- `cache_ar_valid_o` / `cache_ar_ready_i`  out/in  1  refill address handshake
- `cache_ar_addr_o`  out  ADDR_WIDTH  line-aligned refill address
- `cache_ar_len_o`  out  8  constant `LINE_BEATS-1`; INCR burst
- `cache_r_valid_i` / `cache_r_ready_o`  in/out  1  refill data handshake
- `cache_r_data_i`  in  DATA_WIDTH  refill beat
- `cache_r_resp_i`  in  2  beat response
- `cache_r_last_i`  in  1  last-beat flag
- `fence_i_valid_i` / `fence_i_ready_o`  in/out  1  invalidate-all request

## Operation
- Storage: tag/valid/data arrays held in flops, indexed `[way][set]`. Data arrays are indexed additionally by beat.
- States:
  - `IDLE`: `ar_ready_o=1`. Fence has priority: if `fence_i_valid_i`, go to `FENCE` and hold `ar_ready_o=0` that cycle. On an `ar` handshake, latch the address and go to `LOOKUP`.
  - `LOOKUP`: compare the tag in all ways. On a hit, register the word into `r_data_o`, set `r_resp_o=00`, go to `RESP`. On a miss, choose the victim: the lowest-index invalid way, otherwise `rr_ptr[set]`. Clear that way's valid bit, write the new tag, go to `AR`.
  - `AR`: `cache_ar_valid_o=1`. Hold the address stable until the handshake, then go to `R`.
  - `R`: `cache_r_ready_o=1`. Each accepted beat writes data at `beat_cnt`, then `beat_cnt++`. When the beat index equals the requested beat, capture it into `r_data_o`. Any non-OKAY resp, or `cache_r_last_i` mismatching `beat_cnt==LINE_BEATS-1`, sets sticky `err`. After beat `LINE_BEATS-1`: set valid only if `!err`, advance `rr_ptr[set]` (wraps modulo WAYS) only if a replacement occurred, set `r_resp_o = err ? 10 : 00`, go to `RESP`.
  - `RESP`: `r_data_valid_o=1`, data stable, until `r_data_ready_i`; then go to `IDLE`.
  - `FENCE`: clear all valid bits in one cycle, pulse `fence_i_ready_o=1`, go to `IDLE`. Tags, data and rr pointers are untouched.
- A hit does not update the replacement state.
- `fence_i_valid_i` outside `IDLE` is held pending by the requester; it is serviced after the current fetch completes.

## Timing
- Reset (async assert, sync-safe deassert):
  - state `IDLE`; `ar_ready_o=1`
  - all other outputs 0; `r_data_o=0`
  - all valid 0; `rr_ptr=0`; `beat_cnt=0`
- Hit latency: handshake edge N → `r_data_valid_o` high at N+2.
- Miss latency: handshake N → `cache_ar_valid_o` at N+2 → `RESP` 1 cycle after the last beat.
- `ar_ready_o` is low from the cycle after a handshake until the cycle after the `RESP` handshake. Back-to-back fetches are therefore spaced ≥3 cycles.
- Reset mid-refill: abandon the burst immediately. Downstream must also be reset.

## Configuration
- `YSYX_22050019_ICACHE_PERF_EN` defined: adds ports `perf_hit_o` and `perf_miss_o` (out, 32). These are saturating counters incremented in `LOOKUP` on hit or miss, and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `ysyx_22050019_icache_pkg`:
  - state enum
  - `RESP_OKAY`/`RESP_SLVERR` constants
  - address field slicing functions
- Sub-module `ysyx_22050019_icache_repl`: per-set round-robin pointer array plus invalid-first victim select. Inputs: set, valid vector, update strobe. Output: victim way.

## Test plan
- Cold miss `0x8000_0010` (defaults): one burst with `cache_ar_addr_o=0x8000_0000`, len 3. Response returns beat 2 with OKAY. A re-fetch of `0x8000_0018` hits with latency 2.
- Fill 5 lines mapping to set 0 (stride 0x200): ways 0-3 fill from invalid. The 5th line evicts way 0 (rr 0→1). A re-fetch of the first line misses.
- Beat 1 returns SLVERR: `r_resp_o=10`, line stays invalid, and the next fetch to the same line re-bursts.
- `cache_r_last_i` on beat 2 of 4: SLVERR is returned and the line is not validated.
- `fence_i_valid_i` and `ar_valid_i` together in `IDLE`: fence is served first (`fence_i_ready_o` pulses 1 cycle). A subsequent fetch to a previously cached line misses.
- `r_data_ready_i` held low 5 cycles in `RESP`: `r_data_o`/`r_resp_o` stay stable and `ar_ready_o` stays 0.
